// File: rtl/mips_multicycle_fsm_if.sv
// Control bundle between the multicycle MIPS main FSM (master) and the datapath (slave).
interface mips_multicycle_fsm_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       PCWriteCond;
    logic       PCWrite;
    logic       IorD;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, mem_ready,
        output MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
               PCWriteCond, PCWrite, IorD, ALUSrcB, ALUOp, PCSource,
               instr_done, illegal_op, state
    );

    modport slave (
        output op, mem_ready,
        input  MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
               PCWriteCond, PCWrite, IorD, ALUSrcB, ALUOp, PCSource,
               instr_done, illegal_op, state
    );
endinterface

// File: rtl/mips_multicycle_fsm.sv
// Multicycle MIPS main control FSM: one state per cycle, stalls on mem_ready in
// FETCH / MEM_READ / MEM_WRITE, strobes decoded from the state register.
module mips_multicycle_fsm (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctl_t;

    state_e state_q;
    logic   illegal_q;
    ctl_t   ctl_s;

    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
            default:                                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State register and sticky illegal-opcode flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH:     state_q <= bus.mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state_q <= S_MEM_ADDR;
                        OP_R:         state_q <= S_R_EXEC;
                        OP_ADDI:      state_q <= S_I_EXEC;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_J:         state_q <= S_JUMP;
                        default: begin
                            state_q   <= S_FETCH;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR:  state_q <= (bus.op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  state_q <= bus.mem_ready ? S_MEM_WB : S_MEM_READ;
                S_MEM_WRITE: state_q <= bus.mem_ready ? S_FETCH : S_MEM_WRITE;
                S_R_EXEC:    state_q <= S_R_WB;
                S_I_EXEC:    state_q <= S_I_WB;
                default:     state_q <= S_FETCH;
            endcase
        end
    end

    // Moore strobe decode; reset forces every strobe and select to zero.
    always_comb begin
        ctl_s = '0;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    ctl_s.mem_read  = 1'b1;
                    ctl_s.alu_src_b = 2'b01;
                    ctl_s.ir_write  = bus.mem_ready;
                    ctl_s.pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    ctl_s.alu_src_b  = 2'b11;
                    ctl_s.instr_done = ~op_legal(bus.op);
                end
                S_MEM_ADDR, S_I_EXEC: begin
                    ctl_s.alu_src_a = 1'b1;
                    ctl_s.alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    ctl_s.mem_read = 1'b1;
                    ctl_s.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    ctl_s.reg_write  = 1'b1;
                    ctl_s.memto_reg  = 1'b1;
                    ctl_s.instr_done = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctl_s.mem_write  = 1'b1;
                    ctl_s.i_or_d     = 1'b1;
                    ctl_s.instr_done = bus.mem_ready;
                end
                S_R_EXEC: begin
                    ctl_s.alu_src_a = 1'b1;
                    ctl_s.alu_op    = 2'b10;
                end
                S_R_WB: begin
                    ctl_s.reg_write  = 1'b1;
                    ctl_s.reg_dst    = 1'b1;
                    ctl_s.instr_done = 1'b1;
                end
                S_I_WB: begin
                    ctl_s.reg_write  = 1'b1;
                    ctl_s.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ctl_s.alu_src_a     = 1'b1;
                    ctl_s.alu_op        = 2'b01;
                    ctl_s.pc_write_cond = 1'b1;
                    ctl_s.pc_source     = 2'b01;
                    ctl_s.instr_done    = 1'b1;
                end
                S_JUMP: begin
                    ctl_s.pc_write   = 1'b1;
                    ctl_s.pc_source  = 2'b10;
                    ctl_s.instr_done = 1'b1;
                end
                default: ctl_s = '0;
            endcase
        end else begin
            ctl_s = '0;
        end
    end

    assign bus.MemRead     = ctl_s.mem_read;
    assign bus.MemWrite    = ctl_s.mem_write;
    assign bus.IRWrite     = ctl_s.ir_write;
    assign bus.MemtoReg    = ctl_s.memto_reg;
    assign bus.RegDst      = ctl_s.reg_dst;
    assign bus.RegWrite    = ctl_s.reg_write;
    assign bus.ALUSrcA     = ctl_s.alu_src_a;
    assign bus.PCWriteCond = ctl_s.pc_write_cond;
    assign bus.PCWrite     = ctl_s.pc_write;
    assign bus.IorD        = ctl_s.i_or_d;
    assign bus.ALUSrcB     = ctl_s.alu_src_b;
    assign bus.ALUOp       = ctl_s.alu_op;
    assign bus.PCSource    = ctl_s.pc_source;
    assign bus.instr_done  = ctl_s.instr_done;
    assign bus.illegal_op  = illegal_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_mips_multicycle_fsm.sv
// Scoreboard bench for mips_multicycle_fsm: per-cycle expected control words are
// queued as stimulus is generated and compared against the DUT on the falling edge.
module tb_mips_multicycle_fsm;
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MADDR = 4'd2, MREAD = 4'd3,
                           MWB = 4'd4, MWRITE = 4'd5, REXEC = 4'd6, RWB = 4'd7,
                           IEXEC = 4'd8, IWB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11;
    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                           OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08, OP_BAD = 6'h3F;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_multicycle_fsm_if bus ();
    mips_multicycle_fsm dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [21:0] exp;
        string       tag;
    } entry_t;

    entry_t sb_q[$];
    int     n_cmp = 0;
    int     n_mis = 0;
    logic   ill_exp = 1'b0;
    int     done_cnt, irw_cnt, mw_cnt, rw_cnt, fetch_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference control word straight from the state table.
    function automatic logic [21:0] model(input logic [3:0] st, input logic mr,
                                          input logic [5:0] op, input logic ill);
        logic mrd, mwr, irw, m2r, rdst, rw, asa, pwc, pw, iod, done;
        logic [1:0] asb, aop, psrc;
        {mrd, mwr, irw, m2r, rdst, rw, asa, pwc, pw, iod, done} = 11'd0;
        {asb, aop, psrc} = 6'd0;
        case (st)
            FETCH:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
            DECODE: begin asb = 2'b11;
                          done = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI}); end
            MADDR:  begin asa = 1'b1; asb = 2'b10; end
            MREAD:  begin mrd = 1'b1; iod = 1'b1; end
            MWB:    begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
            MWRITE: begin mwr = 1'b1; iod = 1'b1; done = mr; end
            REXEC:  begin asa = 1'b1; aop = 2'b10; end
            RWB:    begin rw = 1'b1; rdst = 1'b1; done = 1'b1; end
            IEXEC:  begin asa = 1'b1; asb = 2'b10; end
            IWB:    begin rw = 1'b1; done = 1'b1; end
            BRANCH: begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; done = 1'b1; end
            JUMP:   begin pw = 1'b1; psrc = 2'b10; done = 1'b1; end
            default: ;
        endcase
        return {mrd, mwr, irw, m2r, rdst, rw, asa, pwc, pw, iod, asb, aop, psrc, done, ill, st};
    endfunction

    function automatic logic [21:0] obs_vec();
        return {bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                bus.ALUSrcA, bus.PCWriteCond, bus.PCWrite, bus.IorD, bus.ALUSrcB, bus.ALUOp,
                bus.PCSource, bus.instr_done, bus.illegal_op, bus.state};
    endfunction

    task automatic push(input logic [3:0] st, input logic [5:0] op, input logic mr, input string tag);
        entry_t e;
        e.op  = op;
        e.mr  = mr;
        e.exp = model(st, mr, op, ill_exp);
        e.tag = $sformatf("%s_s%0d", tag, st);
        sb_q.push_back(e);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected per-cycle trace of one instruction; op_late is driven after MEM_ADDR.
    task automatic gen(input logic [5:0] opc, input int fw, input int mw,
                       input logic [5:0] op_late, input string tag);
        for (int i = 0; i < fw; i++) push(FETCH, opc, 1'b0, tag);
        push(FETCH, opc, 1'b1, tag);
        push(DECODE, opc, rnd(), tag);
        case (opc)
            OP_LW: begin
                push(MADDR, opc, rnd(), tag);
                for (int i = 0; i < mw; i++) push(MREAD, op_late, 1'b0, tag);
                push(MREAD, op_late, 1'b1, tag);
                push(MWB, op_late, rnd(), tag);
            end
            OP_SW: begin
                push(MADDR, opc, rnd(), tag);
                for (int i = 0; i < mw; i++) push(MWRITE, op_late, 1'b0, tag);
                push(MWRITE, op_late, 1'b1, tag);
            end
            OP_R:    begin push(REXEC, op_late, rnd(), tag); push(RWB, op_late, rnd(), tag); end
            OP_ADDI: begin push(IEXEC, op_late, rnd(), tag); push(IWB, op_late, rnd(), tag); end
            OP_BEQ:  push(BRANCH, op_late, rnd(), tag);
            OP_J:    push(JUMP, op_late, rnd(), tag);
            default: ill_exp = 1'b1;
        endcase
    endtask

    task automatic clr_cnt();
        done_cnt = 0; irw_cnt = 0; mw_cnt = 0; rw_cnt = 0; fetch_cnt = 0;
    endtask

    // Entered and left at posedge+1: drive, compare at negedge, advance one clock.
    task automatic run(input int n);
        entry_t e;
        for (int i = 0; i < n && sb_q.size() > 0; i++) begin
            e = sb_q.pop_front();
            bus.op = e.op;
            bus.mem_ready = e.mr;
            @(negedge clk);
            check_val(e.tag, obs_vec(), e.exp);
            done_cnt  += int'(bus.instr_done);
            irw_cnt   += int'(bus.IRWrite);
            mw_cnt    += int'(bus.MemWrite);
            rw_cnt    += int'(bus.RegWrite);
            fetch_cnt += int'(bus.state == FETCH);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        entry_t e;
        rst = 1'b0;
        bus.op = OP_R;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_init", obs_vec(), 22'd0);
        rst = 1'b1;

        clr_cnt();
        gen(OP_LW, 0, 0, OP_LW, "zw_lw");
        gen(OP_SW, 0, 0, OP_SW, "zw_sw");
        gen(OP_R, 0, 0, OP_R, "zw_r");
        gen(OP_ADDI, 0, 0, OP_ADDI, "zw_addi");
        gen(OP_BEQ, 0, 0, OP_BEQ, "zw_beq");
        gen(OP_J, 0, 0, OP_J, "zw_j");
        run(23);
        check_val("zw_done_cnt", done_cnt, 6);
        check_val("zw_fetch_cnt", fetch_cnt, 6);

        clr_cnt();
        gen(OP_LW, 2, 3, OP_LW, "ws_lw");
        run(10);
        check_val("ws_irwrite_cnt", irw_cnt, 1);
        check_val("ws_done_cnt", done_cnt, 1);
        check_val("ws_back_fetch", 32'(bus.state), 32'(FETCH));

        clr_cnt();
        gen(OP_SW, 0, 1, OP_SW, "ws_sw");
        run(5);
        check_val("sw_memwrite_cnt", mw_cnt, 2);
        check_val("sw_done_cnt", done_cnt, 1);
        check_val("sw_regwrite_cnt", rw_cnt, 0);

        clr_cnt();
        gen(OP_LW, 0, 1, OP_SW, "opchg_lw");
        run(6);
        check_val("opchg_regwrite_cnt", rw_cnt, 1);

        clr_cnt();
        gen(OP_BAD, 0, 0, OP_BAD, "ill");
        run(2);
        check_val("ill_regwrite_cnt", rw_cnt, 0);
        check_val("ill_memwrite_cnt", mw_cnt, 0);
        check_val("ill_done_cnt", done_cnt, 1);
        gen(OP_ADDI, 1, 0, OP_ADDI, "post_ill_addi");
        run(5);
        check_val("ill_sticky", 32'(bus.illegal_op), 32'd1);

        gen(OP_R, 0, 0, OP_R, "rst_r");
        run(2);
        e = sb_q.pop_front();
        bus.op = e.op;
        bus.mem_ready = e.mr;
        #2;
        check_val(e.tag, obs_vec(), e.exp);
        bus.mem_ready = 1'b1;
        rst = 1'b0;
        #1;
        check_val("rst_async_mid_rexec", obs_vec(), 22'd0);
        sb_q.delete();
        ill_exp = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_hold", obs_vec(), 22'd0);
        rst = 1'b1;
        clr_cnt();
        gen(OP_J, 0, 0, OP_J, "post_rst_j");
        run(3);
        check_val("post_rst_irwrite", irw_cnt, 1);
        check_val("post_rst_done", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_fsm.md
# mips_multicycle_fsm

Main control state machine for the multicycle MIPS core. It decodes the 6-bit opcode latched in IR and drives every datapath strobe and mux select (PC, IR, MDR/memory, register file, ALU sources, ALUOp) one state per cycle. It also stalls on a memory-ready handshake, so instruction and data memory may take any number of cycles. It sits between the instruction decoder's `op` field and the datapath, alongside `alu_control`, which consumes its `ALUOp`.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `op`  in  6  opcode from IR[31:26]; valid from DECODE onward.
- `mem_ready`  in  1  memory handshake; the current access completes in a cycle where this is 1.
- `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA`, `PCWriteCond`, `PCWrite`, `IorD`  out  1 each  standard multicycle strobes/selects.
- `ALUSrcB`  out  2  ALU B-input select: 00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `ALUOp`  out  2  to `alu_control`: 00=add, 01=sub, 10=funct field.
- `PCSource`  out  2  PC mux select: 00=ALU result, 01=ALUOut, 10=jump target.
- `instr_done`  out  1  high in the final cycle of each instruction.
- `illegal_op`  out  1  sticky flag: an unsupported opcode was decoded.
- `state`  out  4  current state encoding, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Outputs are Moore (decoded from `state`), with two exceptions: `IRWrite`/`PCWrite` in FETCH and `instr_done` in the memory-wait states are ANDed with `mem_ready`.
- Any output not listed for a state is 0.
- States and transitions:
  - FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. Stay while !mem_ready; otherwise go to DECODE.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by op: lw/sw to MEM_ADDR, R to R_EXEC, addi to I_EXEC, beq to BRANCH, j to JUMP. Any other op goes to FETCH, sets illegal_op, and pulses instr_done.
  - MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw to MEM_READ, sw to MEM_WRITE.
  - MEM_READ (3): MemRead=1, IorD=1. Wait for mem_ready, then go to MEM_WB.
  - MEM_WB (4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next: FETCH.
  - MEM_WRITE (5): MemWrite=1, IorD=1, instr_done=mem_ready. Wait for mem_ready, then go to FETCH.
  - R_EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: R_WB.
  - R_WB (7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next: FETCH.
  - I_EXEC (8): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: I_WB.
  - I_WB (9): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Next: FETCH.
  - BRANCH (10): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next: FETCH.
  - JUMP (11): PCWrite=1, PCSource=10, instr_done=1. Next: FETCH.
  - Encodings 12–15 are unreachable. If entered, they behave as FETCH with all strobes 0, and the next state is FETCH.
- `op` is sampled only in DECODE and MEM_ADDR. Changes to `op` in other states have no effect.
- `mem_ready` is ignored outside FETCH, MEM_READ and MEM_WRITE.

## Timing
- Reset (`rst`=0, asynchronous): state=FETCH and illegal_op=0 immediately. All strobes (MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite, instr_done) are forced to 0 while `rst`=0, regardless of mem_ready. Selects read 0.
- Reset mid-instruction aborts the instruction with no register or memory write. The first cycle after deassertion is FETCH.
- With zero-wait memory (`mem_ready` tied 1), cycles per instruction are: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. The strobes hold steady throughout the wait.
- `instr_done` is high for exactly one cycle per instruction. That cycle is followed by FETCH.
- `illegal_op` is set on the clock edge leaving DECODE with an illegal op. It is cleared only by reset.

## Test plan
- Reset: assert `rst`=0 mid-R_EXEC. Required: state=0 and all strobes 0 without a clock edge. After release with mem_ready=1, IRWrite=PCWrite=1 in the first cycle.
- Zero-wait sequence lw, sw, R(0x00), addi(0x08), beq(0x04), j(0x02) with mem_ready=1. Required: state traces 0-1-2-3-4, 0-1-2-5, 0-1-6-7, 0-1-8-9, 0-1-10, 0-1-11, with one instr_done per instruction; 23 cycles total.
- Wait states: lw with mem_ready low for 2 cycles in FETCH and 3 in MEM_READ. Required: IRWrite is asserted only on the ready cycle, MemRead/IorD=1 are held, and lw completes in 10 cycles.
- sw with mem_ready low for 1 cycle in MEM_WRITE. Required: MemWrite is high for 2 cycles, instr_done pulses only on the second, and there is no RegWrite.
- Illegal op 0x3F. Required: DECODE goes to FETCH, illegal_op=1 from then on until reset, and no RegWrite/MemWrite is issued.
- Change `op` from lw to sw while in MEM_READ. Required: the FSM still goes to MEM_WB with RegWrite=1 and MemtoReg=1.
